stim_generator: RTL and testbench

STIM_GENERATOR -- requirements
Module: stim_generator

---
 rtl/stim_generator_if.sv | 22 ++
 rtl/stim_generator.sv | 211 +++++++++++++++++++++
 tb/tb_stim_generator.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stim_generator_if.sv
// Handshake bundle between stim_generator (master) and the block core it drives (slave).
interface stim_generator_if #(
  parameter int DATA_W = 128
);
  logic [DATA_W-1:0] core_key;
  logic              core_init;
  logic              core_next;
  logic [DATA_W-1:0] core_block;
  logic              core_ready;
  logic [DATA_W-1:0] core_result;
  logic              core_result_valid;

  modport master (
    output core_key, core_init, core_next, core_block,
    input  core_ready, core_result, core_result_valid
  );

  modport slave (
    input  core_key, core_init, core_next, core_block,
    output core_ready, core_result, core_result_valid
  );
endinterface

// File: rtl/stim_generator.sv
// Burst stimulus generator feeding a block core, with data/result FWFT FIFOs.
// Optional statistics counters are enabled by defining STIM_GENERATOR_STATS_EN.

module stim_generator_fifo #(
  parameter int W  = 128,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd && !empty;
  assign do_wr   = wr && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

module stim_generator #(
  parameter int          DATA_W    = 128,
  parameter int          DFIFO_AW  = 2,
  parameter int          RFIFO_AW  = 4,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [15:0]       burst_len,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] key,
  input  logic              write_key,
  stim_generator_if.master  core,
  input  logic              data_require,
  output logic [DATA_W-1:0] data,
  output logic              data_empty,
  input  logic              result_require,
  output logic [DATA_W-1:0] result,
  output logic              result_empty,
  output logic              busy,
  output logic              done,
  output logic              res_overflow,
  output logic [31:0]       issued_cnt,
  output logic [31:0]       completed_cnt
);
  localparam int           LANES       = DATA_W / 32;
  localparam logic [127:0] KEY_DEFAULT = 128'hab7240f9_c5e0bb5e_ee8e34b6_bb84cfb0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {MODE_LFSR, MODE_INC, MODE_FIXED, MODE_WALK} mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic [DATA_W-1:0] gen_q, gen_reload, gen_adv, lfsr_seed, lfsr_adv;
  logic [DATA_W-1:0] key_q, core_block_q;
  logic [15:0]       remaining_q;
  logic              outstanding_q, valid_q, core_next_q, core_init_q, res_overflow_q;
  logic              start_ok, issue, last_issue, key_load, res_edge, res_drop;
  logic              dfifo_full, rfifo_full;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  assign start_ok   = start && !abort && (state_q == IDLE || state_q == DONE);
  assign issue      = (state_q == RUN) && !abort && core.core_ready && !dfifo_full && !outstanding_q;
  assign last_issue = issue && (remaining_q == 16'd1);
  assign key_load   = write_key && (state_q != RUN);
  assign res_edge   = core.core_result_valid && !valid_q;
  assign res_drop   = res_edge && rfifo_full && !result_require;

  always_comb begin
    lfsr_seed = '0;
    lfsr_adv  = '0;
    for (int i = 0; i < LANES; i++) begin
      lfsr_seed[32*i +: 32] = LFSR_SEED ^ 32'(i);
      lfsr_adv[32*i +: 32]  = lfsr_step(gen_q[32*i +: 32]);
    end
  end

  // Reload uses the live mode input; advance uses the mode captured at start.
  always_comb begin
    gen_reload = '0;
    gen_adv    = gen_q;
    case (mode_t'(mode))
      MODE_LFSR:  gen_reload = lfsr_seed;
      MODE_INC:   gen_reload = '0;
      MODE_FIXED: gen_reload = pattern;
      default:    gen_reload = DATA_W'(1);
    endcase
    case (mode_q)
      MODE_LFSR:  gen_adv = lfsr_adv;
      MODE_INC:   gen_adv = gen_q + DATA_W'(1);
      MODE_FIXED: gen_adv = pattern;
      default:    gen_adv = {gen_q[DATA_W-2:0], gen_q[DATA_W-1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_ok) state_d = RUN;
      RUN:        if (abort) state_d = IDLE; else if (last_issue) state_d = DRAIN;
      DRAIN:      if (abort) state_d = IDLE; else if (!outstanding_q) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // core_init resets high so the core expands the default key right after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      mode_q         <= MODE_LFSR;
      gen_q          <= '0;
      remaining_q    <= '0;
      outstanding_q  <= 1'b0;
      valid_q        <= 1'b0;
      core_next_q    <= 1'b0;
      core_block_q   <= '0;
      key_q          <= DATA_W'(KEY_DEFAULT);
      core_init_q    <= 1'b1;
      res_overflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= core.core_result_valid;
      core_next_q <= issue;
      core_init_q <= key_load;
      if (start_ok) begin
        gen_q       <= gen_reload;
        mode_q      <= mode_t'(mode);
        remaining_q <= burst_len;
      end else if (issue) begin
        gen_q <= gen_adv;
        if (remaining_q != 16'd0) remaining_q <= remaining_q - 16'd1;
      end
      if (issue) begin
        core_block_q  <= gen_q;
        outstanding_q <= 1'b1;
      end else if (res_edge) begin
        outstanding_q <= 1'b0;
      end
      if (key_load) key_q <= key;
      if (res_drop) res_overflow_q <= 1'b1;
    end
  end

  stim_generator_fifo #(.W(DATA_W), .AW(DFIFO_AW)) u_dfifo (
    .clk(clk), .rst_n(rst_n), .wr(issue), .wr_data(gen_q), .rd(data_require),
    .rd_data(data), .empty(data_empty), .full(dfifo_full)
  );

  stim_generator_fifo #(.W(DATA_W), .AW(RFIFO_AW)) u_rfifo (
    .clk(clk), .rst_n(rst_n), .wr(res_edge), .wr_data(core.core_result), .rd(result_require),
    .rd_data(result), .empty(result_empty), .full(rfifo_full)
  );

`ifdef STIM_GENERATOR_STATS_EN
  logic [31:0] issued_q, completed_q;

  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      issued_q    <= '0;
      completed_q <= '0;
    end else begin
      if (issue && issued_q != 32'hFFFF_FFFF) issued_q <= issued_q + 32'd1;
      if (res_edge && completed_q != 32'hFFFF_FFFF) completed_q <= completed_q + 32'd1;
    end
  end

  assign issued_cnt    = issued_q;
  assign completed_cnt = completed_q;
`else
  assign issued_cnt    = '0;
  assign completed_cnt = '0;
`endif

  assign core.core_key   = key_q;
  assign core.core_init  = core_init_q;
  assign core.core_next  = core_next_q;
  assign core.core_block = core_block_q;
  assign busy            = (state_q == RUN) || (state_q == DRAIN);
  assign done            = (state_q == DONE);
  assign res_overflow    = res_overflow_q;
endmodule

// File: tb/tb_stim_generator.sv
// Directed self-checking bench for stim_generator with a fixed-latency echo core model.
module tb_stim_generator;
  localparam int           DATA_W      = 128;
  localparam int           LAT         = 5;
  localparam logic [127:0] KEY_DEFAULT = 128'hab7240f9_c5e0bb5e_ee8e34b6_bb84cfb0;
  localparam logic [127:0] KEY_NEW     = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] PAT         = {16{8'h0F}};
`ifdef STIM_GENERATOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, start, abort, write_key, data_require, result_require;
  logic [1:0]        mode;
  logic [15:0]       burst_len;
  logic [DATA_W-1:0] pattern, key, data, result;
  logic              data_empty, result_empty, busy, done, res_overflow;
  logic [31:0]       issued_cnt, completed_cnt;

  int checks = 0;
  int failures = 0;
  int pend_cnt = 0;
  int next_pulses = 0;
  int result_pulses = 0;
  logic [127:0] pend_data;
  logic         drain_en = 1'b0;
  logic [127:0] data_log[$];

  stim_generator_if #(.DATA_W(DATA_W)) core_if ();

  stim_generator #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .burst_len(burst_len), .pattern(pattern), .key(key), .write_key(write_key),
    .core(core_if.master),
    .data_require(data_require), .data(data), .data_empty(data_empty),
    .result_require(result_require), .result(result), .result_empty(result_empty),
    .busy(busy), .done(done), .res_overflow(res_overflow),
    .issued_cnt(issued_cnt), .completed_cnt(completed_cnt)
  );

  always #5 clk = ~clk;

  // Echo core: returns the issued block LAT falling edges after core_next.
  always @(negedge clk) begin
    core_if.core_result_valid = 1'b0;
    if (core_if.core_next === 1'b1) begin
      pend_data = core_if.core_block;
      pend_cnt  = LAT;
      next_pulses++;
    end else if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        core_if.core_result_valid = 1'b1;
        core_if.core_result       = pend_data;
        result_pulses++;
      end
    end
  end

  always @(negedge clk) begin
    if (drain_en && data_empty === 1'b0) begin
      data_log.push_back(data);
      data_require = 1'b1;
    end else begin
      data_require = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [127:0] logged(input int idx);
    if (idx >= 0 && idx < data_log.size()) return data_log[idx];
    return {128{1'bx}};
  endfunction

  task automatic applyReset();
    rst_n = 1'b0;
    step(2);
    rst_n         = 1'b1;
    pend_cnt      = 0;
    next_pulses   = 0;
    result_pulses = 0;
    drain_en      = 1'b0;
    data_log.delete();
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [15:0] len, input logic [127:0] pat);
    mode      = m;
    burst_len = len;
    pattern   = pat;
    start     = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) step();
  endtask

  task automatic readResult(input string tag, input logic [127:0] expected);
    checkOutput(tag, result, expected);
    result_require = 1'b1;
    step();
    result_require = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"}, busy, 1'b0);
    checkOutput({tag, " done"}, done, 1'b0);
    checkOutput({tag, " core_next"}, core_if.core_next, 1'b0);
    checkOutput({tag, " core_block"}, core_if.core_block, '0);
    checkOutput({tag, " data_empty"}, data_empty, 1'b1);
    checkOutput({tag, " result_empty"}, result_empty, 1'b1);
    checkOutput({tag, " res_overflow"}, res_overflow, 1'b0);
    checkOutput({tag, " core_key"}, core_if.core_key, KEY_DEFAULT);
    checkOutput({tag, " issued_cnt"}, issued_cnt, 0);
    checkOutput({tag, " completed_cnt"}, completed_cnt, 0);
    checkOutput({tag, " core_init high"}, core_if.core_init, 1'b1);
    step();
    checkOutput({tag, " core_init low"}, core_if.core_init, 1'b0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    start = 1'b0; abort = 1'b0; write_key = 1'b0; result_require = 1'b0;
    mode = 2'd0; burst_len = 16'd0; pattern = '0; key = '0;
    core_if.core_ready = 1'b1; core_if.core_result_valid = 1'b0; core_if.core_result = '0;

    applyReset();
    checkResetState("reset");

    key = KEY_NEW; write_key = 1'b1;
    step();
    write_key = 1'b0;
    checkOutput("idle key load", core_if.core_key, KEY_NEW);
    checkOutput("idle key init pulse", core_if.core_init, 1'b1);
    step();
    checkOutput("idle key init end", core_if.core_init, 1'b0);

    applyReset();
    drain_en = 1'b1;
    applyStimulus(2'd1, 16'd3, '0);
    checkOutput("inc busy", busy, 1'b1);
    waitDone(300);
    checkOutput("inc done", done, 1'b1);
    checkOutput("inc data count", 128'(data_log.size()), 3);
    checkOutput("inc data0", logged(0), 128'd0);
    checkOutput("inc data1", logged(1), 128'd1);
    checkOutput("inc data2", logged(2), 128'd2);
    readResult("inc result0", 128'd0);
    readResult("inc result1", 128'd1);
    readResult("inc result2", 128'd2);
    checkOutput("inc result empty", result_empty, 1'b1);
    checkOutput("inc issued_cnt", issued_cnt, STATS ? 32'd3 : 32'd0);
    checkOutput("inc completed_cnt", completed_cnt, STATS ? 32'd3 : 32'd0);

    applyReset();
    drain_en = 1'b1;
    applyStimulus(2'd0, 16'd2, '0);
    waitDone(300);
    checkOutput("lfsr done", done, 1'b1);
    checkOutput("lfsr block0", logged(0), 128'hACE10002_ACE10003_ACE10000_ACE10001);
    checkOutput("lfsr block1", logged(1), 128'h56708001_D6508002_56708000_D6508003);

    applyReset();
    applyStimulus(2'd3, 16'd129, '0);
    step(80);
    checkOutput("walk stall data_empty", data_empty, 1'b0);
    checkOutput("walk stall last block", core_if.core_block, 128'h8);
    checkOutput("walk stall busy", busy, 1'b1);
    checkOutput("walk stall issued_cnt", issued_cnt, STATS ? 32'd4 : 32'd0);
    drain_en = 1'b1;
    for (int i = 0; i < 3000 && data_log.size() < 129; i++) step();
    checkOutput("walk data count", 128'(data_log.size()), 129);
    checkOutput("walk block0", logged(0), 128'h1);
    checkOutput("walk block3", logged(3), 128'h8);
    checkOutput("walk block127", logged(127), {1'b1, 127'b0});
    checkOutput("walk block128 wrap", logged(128), 128'h1);
    waitDone(100);
    checkOutput("walk done", done, 1'b1);

    applyReset();
    drain_en = 1'b1;
    applyStimulus(2'd2, 16'd0, PAT);
    mode = 2'd1;
    for (int i = 0; i < 1000 && result_pulses < 17; i++) step();
    checkOutput("fixed result pulses", 128'(result_pulses), 17);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("fixed abort busy", busy, 1'b0);
    checkOutput("fixed res_overflow", res_overflow, 1'b1);
    checkOutput("fixed completed_cnt", completed_cnt, STATS ? 32'd17 : 32'd0);
    checkOutput("fixed issued_cnt", issued_cnt, STATS ? 32'd17 : 32'd0);
    checkOutput("fixed last data", logged(data_log.size() - 1), PAT);
    for (int i = 0; i < 16; i++) readResult($sformatf("fixed result%0d", i), PAT);
    checkOutput("fixed result empty", result_empty, 1'b1);

    applyReset();
    drain_en = 1'b1;
    applyStimulus(2'd1, 16'd5, '0);
    for (int i = 0; i < 50 && core_if.core_next !== 1'b1; i++) step();
    checkOutput("abort first next", core_if.core_next, 1'b1);
    key = KEY_NEW; write_key = 1'b1;
    step();
    write_key = 1'b0;
    checkOutput("run key ignored", core_if.core_key, KEY_DEFAULT);
    checkOutput("run key no init", core_if.core_init, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort done", done, 1'b0);
    step(15);
    checkOutput("abort next pulses", 128'(next_pulses), 1);
    checkOutput("abort late result present", result_empty, 1'b0);
    checkOutput("abort late result", result, 128'd0);
    checkOutput("abort data count", 128'(data_log.size()), 1);

    applyReset();
    applyStimulus(2'd1, 16'd10, '0);
    step(12);
    checkOutput("midreset precondition", data_empty, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkResetState("midreset");
    step(3);
    checkOutput("midreset stays idle", busy, 1'b0);
    checkOutput("midreset no next", core_if.core_next, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
